// File: rtl/bank_pop_scheduler.sv
// Read/write bank scheduler: picks one FIFO to pop per cycle, preferring open-row hits, else round-robin.
// Optional macro BANK_STARVE_LIMIT_EN caps consecutive row-hit grants at STARVE_LIMIT.
module bank_pop_scheduler #(
    parameter int RA_BITS      = 16,
    parameter int ARR_NUM_RD   = 4,
    parameter int ARR_NUM_WR   = 3,
    parameter int RD_W         = 23,
    parameter int WR_W         = 39,
    parameter int WR_CAP       = 6,
    parameter int WR_HIGH_WM   = 4,
    parameter int WR_LOW_WM    = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [ARR_NUM_RD+ARR_NUM_WR-1:0]   push,
    input  logic [ARR_NUM_RD+ARR_NUM_WR-1:0]   not_empty,
    input  logic [ARR_NUM_RD*RD_W-1:0]         rd_head,
    input  logic [ARR_NUM_WR*WR_W-1:0]         wr_head,
    output logic [ARR_NUM_RD+ARR_NUM_WR-1:0]   pop,
    output logic                               cmd_valid,
    input  logic                               cmd_ready,
    output logic                               cmd_type,
    output logic [WR_W-1:0]                    cmd_data,
    output logic [2:0]                         cmd_src,
    output logic [RA_BITS-1:0]                 open_row,
    output logic                               open_row_valid
);
    localparam int N    = ARR_NUM_RD + ARR_NUM_WR;
    localparam int WC_W = $clog2(WR_CAP + 1);
    localparam int RP_W = (ARR_NUM_RD > 1) ? $clog2(ARR_NUM_RD) : 1;
    localparam int WP_W = (ARR_NUM_WR > 1) ? $clog2(ARR_NUM_WR) : 1;
    localparam logic [WC_W-1:0] WC_MAX  = WC_W'(WR_CAP);
    localparam logic [WC_W-1:0] HIGH_WM = WC_W'(WR_HIGH_WM);
    localparam logic [WC_W-1:0] LOW_WM  = WC_W'(WR_LOW_WM);

    typedef enum logic {MODE_RD = 1'b0, MODE_WR = 1'b1} mode_t;

    mode_t                  mode, mode_nxt;
    logic [WC_W-1:0]        wr_count;
    logic [RP_W-1:0]        rd_ptr;
    logic [WP_W-1:0]        wr_ptr;
    logic [ARR_NUM_RD-1:0]  rd_ne, rd_gnt;
    logic [ARR_NUM_WR-1:0]  wr_ne, wr_gnt;
    logic                   grant, force_rr, wr_push, wr_pop;
    logic [WR_W-1:0]        sel_data;
    logic [RA_BITS-1:0]     sel_row;
    logic [2:0]             sel_src;
    int                     sel_idx;
    logic                   unused_rd_push;

    assign rd_ne   = not_empty[ARR_NUM_RD-1:0];
    assign wr_ne   = not_empty[N-1:ARR_NUM_RD];
    assign wr_push = |push[N-1:ARR_NUM_RD];
    assign wr_pop  = grant && (mode == MODE_WR);
    // Read-side pushes never influence scheduling; only not_empty matters.
    assign unused_rd_push = |push[ARR_NUM_RD-1:0];

    always_ff @(posedge clk) begin
        if (rst) mode <= MODE_RD;
        else     mode <= mode_nxt;
    end

    always_comb begin
        mode_nxt = mode;
        case (mode)
            MODE_RD: if (wr_count >= HIGH_WM || (rd_ne == '0 && wr_count != '0)) mode_nxt = MODE_WR;
            MODE_WR: if (wr_count == '0 || (wr_count <= LOW_WM && rd_ne != '0)) mode_nxt = MODE_RD;
            default: mode_nxt = MODE_RD;
        endcase
    end

    // Arbitration: row hit (lowest index) first, then round-robin from the pointer with wrap.
    always_comb begin
        rd_gnt   = '0;
        wr_gnt   = '0;
        grant    = 1'b0;
        sel_idx  = 0;
        sel_data = '0;
        sel_row  = '0;
        sel_src  = '0;
        if (!rst && mode_nxt == mode && (!cmd_valid || cmd_ready)) begin
            if (mode == MODE_RD) begin
                for (int i = 0; i < ARR_NUM_RD; i++)
                    if (!grant && !force_rr && open_row_valid && rd_ne[i] &&
                        rd_head[i*RD_W +: RA_BITS] == open_row) begin
                        grant = 1'b1; rd_gnt[i] = 1'b1; sel_idx = i;
                    end
                for (int i = 0; i < ARR_NUM_RD; i++)
                    if (!grant && rd_ne[i] && i >= int'(rd_ptr)) begin
                        grant = 1'b1; rd_gnt[i] = 1'b1; sel_idx = i;
                    end
                for (int i = 0; i < ARR_NUM_RD; i++)
                    if (!grant && rd_ne[i]) begin
                        grant = 1'b1; rd_gnt[i] = 1'b1; sel_idx = i;
                    end
            end else begin
                for (int i = 0; i < ARR_NUM_WR; i++)
                    if (!grant && !force_rr && open_row_valid && wr_ne[i] &&
                        wr_head[i*WR_W +: RA_BITS] == open_row) begin
                        grant = 1'b1; wr_gnt[i] = 1'b1; sel_idx = i;
                    end
                for (int i = 0; i < ARR_NUM_WR; i++)
                    if (!grant && wr_ne[i] && i >= int'(wr_ptr)) begin
                        grant = 1'b1; wr_gnt[i] = 1'b1; sel_idx = i;
                    end
                for (int i = 0; i < ARR_NUM_WR; i++)
                    if (!grant && wr_ne[i]) begin
                        grant = 1'b1; wr_gnt[i] = 1'b1; sel_idx = i;
                    end
            end
        end
        for (int i = 0; i < ARR_NUM_RD; i++)
            if (rd_gnt[i]) begin
                sel_data = WR_W'(rd_head[i*RD_W +: RD_W]);
                sel_row  = rd_head[i*RD_W +: RA_BITS];
                sel_src  = 3'(i);
            end
        for (int i = 0; i < ARR_NUM_WR; i++)
            if (wr_gnt[i]) begin
                sel_data = wr_head[i*WR_W +: WR_W];
                sel_row  = wr_head[i*WR_W +: RA_BITS];
                sel_src  = 3'(ARR_NUM_RD + i);
            end
    end

    assign pop = {wr_gnt, rd_gnt};

`ifdef BANK_STARVE_LIMIT_EN
    localparam int HC_W = $clog2(STARVE_LIMIT + 1);
    logic [HC_W-1:0] hit_cnt;
    logic            hit_grant;

    // While not forced, the winner matches open_row exactly when it came from the hit pass.
    assign force_rr  = (hit_cnt == HC_W'(STARVE_LIMIT));
    assign hit_grant = open_row_valid && (sel_row == open_row) && !force_rr;

    always_ff @(posedge clk) begin
        if (rst)        hit_cnt <= '0;
        else if (grant) hit_cnt <= hit_grant ? hit_cnt + 1'b1 : '0;
    end
`else
    assign force_rr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_valid      <= 1'b0;
            cmd_type       <= 1'b0;
            cmd_data       <= '0;
            cmd_src        <= '0;
            open_row       <= '0;
            open_row_valid <= 1'b0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            wr_count       <= '0;
        end else begin
            if (grant) begin
                cmd_valid      <= 1'b1;
                cmd_type       <= (mode == MODE_RD);
                cmd_data       <= sel_data;
                cmd_src        <= sel_src;
                open_row       <= sel_row;
                open_row_valid <= 1'b1;
                if (mode == MODE_RD) rd_ptr <= RP_W'((sel_idx + 1) % ARR_NUM_RD);
                else                 wr_ptr <= WP_W'((sel_idx + 1) % ARR_NUM_WR);
            end else if (cmd_ready) begin
                cmd_valid <= 1'b0;
            end
            if (wr_push && !wr_pop && wr_count != WC_MAX)
                wr_count <= wr_count + 1'b1;
            else if (wr_pop && !wr_push && wr_count != '0)
                wr_count <= wr_count - 1'b1;
        end
    end
endmodule
